conv1_mac: RTL

Consumer end of the conv1 window stream: accepts the nine-pixel 3x3 windows that the conv1 window buffer emits with a one-cycle valid strobe. Holds a loadable 3x3 signed kernel plus bias and computes one fixed-point convolution result per window through a 3-stage pipeline. Counts results per output frame and emits a `frame_done` pulse with the last result. Sits between the conv1 window buffer and the next layer's input buffer.

---
 rtl/conv1_pkg.sv | 36 +++
 rtl/conv1_mac_tree.sv | 79 +++++++
 rtl/conv1_mac.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/conv1_pkg.sv
// conv1_pkg: shared constants, FSM state type and the shift/saturate helper
// for the conv1 MAC. The helper is sized for the default 32-bit data path.
package conv1_pkg;

  localparam int NUM_TAPS    = 9;
  localparam int NUM_COEF    = 10;
  localparam int DATA_BITS_P = 32;
  localparam int ACC_BITS    = 2 * DATA_BITS_P + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } conv1_mac_state_t;

  // Floor-shift the accumulator back to the data format, then clamp to the
  // signed data range.
  function automatic logic signed [DATA_BITS_P-1:0] sat_shift(
    input logic signed [ACC_BITS-1:0] total,
    input int                         frac
  );
    logic signed [ACC_BITS-1:0] shifted;
    logic signed [ACC_BITS-1:0] max_v;
    logic signed [ACC_BITS-1:0] min_v;
    shifted = total >>> frac;
    max_v   = {{(ACC_BITS-DATA_BITS_P+1){1'b0}}, {(DATA_BITS_P-1){1'b1}}};
    min_v   = {{(ACC_BITS-DATA_BITS_P+1){1'b1}}, {(DATA_BITS_P-1){1'b0}}};
    if (shifted > max_v)
      sat_shift = max_v[DATA_BITS_P-1:0];
    else if (shifted < min_v)
      sat_shift = min_v[DATA_BITS_P-1:0];
    else
      sat_shift = shifted[DATA_BITS_P-1:0];
  endfunction

endpackage

// File: rtl/conv1_mac_tree.sv
// conv1_mac_tree: pipeline stages 2 and 3 of the conv1 MAC.
//   stage 2: three row sums of the nine stage-1 products (bias carried along)
//   stage 3: add bias << FRAC_BITS, floor-shift, saturate, optional ReLU
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_valid       stage-1 valid
//   i_prod[0:8]   stage-1 products (2*DATA_BITS, signed)
//   i_bias        bias captured with the products
//   o_s2_valid    stage-2 valid (a result is registered on the next edge)
//   o_data        registered result, holds while o_valid is low
//   o_valid       result strobe
// Macro CONV1_MAC_RELU_EN: when defined, negative results are clamped to 0.
module conv1_mac_tree
  import conv1_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [2*DATA_BITS-1:0] i_prod [0:NUM_TAPS-1],
  input  logic [DATA_BITS-1:0]   i_bias,
  output logic                   o_s2_valid,
  output logic [DATA_BITS-1:0]   o_data,
  output logic                   o_valid
);

  localparam int ROW_W = 2 * DATA_BITS + 2;

  logic [ROW_W-1:0]           w_row [0:2];
  logic [ROW_W-1:0]           r_row [0:2];
  logic [DATA_BITS-1:0]       r_bias;
  logic                       r_v2;
  logic signed [ACC_BITS-1:0] w_total;
  logic [DATA_BITS-1:0]       w_sat;
  logic [DATA_BITS-1:0]       w_res;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_row[r] = ROW_W'($signed(i_prod[3*r]))
               + ROW_W'($signed(i_prod[3*r+1]))
               + ROW_W'($signed(i_prod[3*r+2]));
    end
  end

  always_comb begin
    w_total = ACC_BITS'($signed(r_row[0])) + ACC_BITS'($signed(r_row[1]))
            + ACC_BITS'($signed(r_row[2]))
            + (ACC_BITS'($signed(r_bias)) <<< FRAC_BITS);
    w_sat   = sat_shift(w_total, FRAC_BITS);
`ifdef CONV1_MAC_RELU_EN
    w_res   = w_sat[DATA_BITS-1] ? '0 : w_sat;
`else
    w_res   = w_sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) r_row[r] <= '0;
      r_bias  <= '0;
      r_v2    <= 1'b0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      r_v2    <= i_valid;
      o_valid <= r_v2;
      if (i_valid) begin
        for (int r = 0; r < 3; r++) r_row[r] <= w_row[r];
        r_bias <= i_bias;
      end
      if (r_v2) o_data <= w_res;
    end
  end

  assign o_s2_valid = r_v2;

endmodule

// File: rtl/conv1_mac.sv
// conv1_mac: 3x3 fixed-point convolution MAC fed by the conv1 window buffer.
// Owns the coefficient-load FSM, coefficient registers, stage-1 multipliers
// and the output frame counter; stages 2-3 live in conv1_mac_tree.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   valid_in, data_in  window strobe and 9 pixels, row-major
//   w_valid, w_data    coefficient load: weights 0..8 then bias
//   data_out/valid_out result and strobe (latency 3)
//   frame_done         pulse with the last result of a frame
//   ready              coefficient set complete, windows accepted
//   drop_err           sticky: a window was dropped
// Macro CONV1_MAC_RELU_EN: enables ReLU on the result (see conv1_mac_tree).
//
// state | meaning
// EMPTY | no coefficients since reset
// LOAD  | coefficient words 1..9 being received
// READY | full set loaded, windows accepted
module conv1_mac
  import conv1_pkg::*;
#(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 36,
  parameter int DATA_BITS = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in [0:NUM_TAPS-1],
  input  logic                 w_valid,
  input  logic [DATA_BITS-1:0] w_data,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_done,
  output logic                 ready,
  output logic                 drop_err
);

  localparam int FRAME_LEN = (WIDTH - 2) * (HEIGHT - 2);
  localparam int CNT_W     = $clog2(FRAME_LEN);

  conv1_mac_state_t       r_state, w_state_nxt;
  logic [3:0]             r_idx, w_idx_nxt;
  logic                   w_coef_we;
  logic [3:0]             w_coef_sel;
  logic                   w_cnt_clr;
  logic                   w_accept;
  logic [DATA_BITS-1:0]   r_coef [0:NUM_COEF-1];
  logic [2*DATA_BITS-1:0] w_prod [0:NUM_TAPS-1];
  logic [2*DATA_BITS-1:0] r_prod [0:NUM_TAPS-1];
  logic [DATA_BITS-1:0]   r_bias;
  logic                   r_v1;
  logic                   w_s2_valid;
  logic [CNT_W-1:0]       r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_coef_we   = 1'b0;
    w_coef_sel  = 4'd0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      EMPTY: if (w_valid) begin
        w_coef_we   = 1'b1;
        w_idx_nxt   = 4'd1;
        w_state_nxt = LOAD;
      end
      LOAD: if (w_valid) begin
        w_coef_we  = 1'b1;
        w_coef_sel = r_idx;
        w_idx_nxt  = r_idx + 4'd1;
        if (r_idx == 4'(NUM_COEF - 1)) w_state_nxt = READY;
      end
      READY: if (w_valid) begin
        w_coef_we   = 1'b1;
        w_idx_nxt   = 4'd1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = LOAD;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // A reload word in the same cycle as a window wins; the window is dropped.
  assign w_accept = valid_in && (r_state == READY) && !w_valid;
  assign ready    = (r_state == READY);

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_prod[i] = (2*DATA_BITS)'($signed(data_in[i]))
                * (2*DATA_BITS)'($signed(r_coef[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_idx   <= 4'd0;
      for (int i = 0; i < NUM_COEF; i++) r_coef[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_coef_we) r_coef[w_coef_sel] <= w_data;
    end
  end

  // Stage 1 captures the bias with the products so an in-flight window is
  // unaffected by a reload that starts behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_prod[i] <= '0;
      r_bias   <= '0;
      r_v1     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        for (int i = 0; i < NUM_TAPS; i++) r_prod[i] <= w_prod[i];
        r_bias <= r_coef[NUM_COEF-1];
      end
      if (valid_in && !w_accept) drop_err <= 1'b1;
    end
  end

  conv1_mac_tree #(
    .DATA_BITS(DATA_BITS),
    .FRAC_BITS(FRAC_BITS)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (r_v1),
    .i_prod    (r_prod),
    .i_bias    (r_bias),
    .o_s2_valid(w_s2_valid),
    .o_data    (data_out),
    .o_valid   (valid_out)
  );

  // Counted one cycle ahead of the result so frame_done lines up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_s2_valid && (r_cnt == CNT_W'(FRAME_LEN - 1));
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (w_s2_valid)
        r_cnt <= (r_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
